// File: rtl/telemetry_pkg.sv
// Shared types and frame constants for the telemetry sample scheduler.
package telemetry_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        SEND,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    localparam int         NUM_CH        = 4;
    localparam int         FRAME_LEN     = 5;
    localparam logic [7:0] HDR_C         = 8'h43;
    localparam logic [7:0] HDR_H         = 8'h48;
    localparam logic [7:0] CH_ASCII_BASE = 8'h30;

endpackage

// File: rtl/uart_sample_scheduler_if.sv
// Byte handshake between the sample scheduler and uart_tx.
interface uart_sample_scheduler_if;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (output tx_start, output tx_data, input tx_busy);
    modport slave  (input tx_start, input tx_data, output tx_busy);

endinterface

// File: rtl/uart_sample_scheduler_edge_decim.sv
// Rising-edge detect on the codec strobe plus the every-(decim+1)th edge divider.
module sample_edge_decim #(
    parameter int DECIM_W = 8
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               sample_clk,
    input  logic [DECIM_W-1:0] decim,
    output logic               eligible
);

    logic               last_sample_clk;
    logic [DECIM_W-1:0] decim_cnt;
    logic               edge_det;
    logic               cnt_hit;

    assign edge_det = sample_clk & ~last_sample_clk;
    // ">=" rather than "==" so a decim lowered below the running count still fires next edge.
    assign cnt_hit  = (decim_cnt >= decim);
    assign eligible = edge_det & cnt_hit;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (rst) begin
            last_sample_clk <= 1'b0;
            decim_cnt       <= '0;
        end else begin
            last_sample_clk <= sample_clk;
            if (edge_det) begin
                decim_cnt <= cnt_hit ? '0 : decim_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_sample_scheduler.sv
// Snapshots four codec channels on a decimated sample strobe and streams "CH<n>" MSB LSB frames to uart_tx.
module uart_sample_scheduler
    import telemetry_pkg::*;
#(
    parameter int W       = 16,
    parameter int DECIM_W = 8
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic                    sample_clk,
    input  logic [W-1:0]            sample_in0,
    input  logic [W-1:0]            sample_in1,
    input  logic [W-1:0]            sample_in2,
    input  logic [W-1:0]            sample_in3,
    input  logic [NUM_CH-1:0]       ch_enable,
    input  logic [DECIM_W-1:0]      decim,
    uart_sample_scheduler_if.master tx,
    output logic                    sweep_active,
    output logic                    sweep_done,
    output logic [DECIM_W-1:0]      drop_count
);

    state_t            state, state_n;
    logic [W-1:0]      shadow [NUM_CH];
    logic [NUM_CH-1:0] mask_q;
    logic [1:0]        cur_ch, cur_ch_n, first_ch, next_ch;
    logic              next_valid;
    logic [2:0]        byte_idx, byte_idx_n;
    logic [7:0]        cur_byte, tx_data_n;
    logic              tx_start_n, sweep_active_n, sweep_done_n;
    logic              snap_load, eligible, drop_hit;

    sample_edge_decim #(.DECIM_W(DECIM_W)) u_edge_decim (
        .CLK        (CLK),
        .rst        (rst),
        .sample_clk (sample_clk),
        .decim      (decim),
        .eligible   (eligible)
    );

    // The sweep_done cycle still counts as busy, so an edge landing there is a drop.
    assign drop_hit = eligible & (sweep_active | sweep_done);

    // Lowest enabled channel, and lowest enabled channel strictly above cur_ch.
    always_comb begin
        first_ch   = '0;
        next_ch    = '0;
        next_valid = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_ch = 2'(i);
            end
            if (mask_q[i] && (i > int'(cur_ch))) begin
                next_ch    = 2'(i);
                next_valid = 1'b1;
            end
        end
    end

    always_comb begin
        case (byte_idx)
            3'd0:    cur_byte = HDR_C;
            3'd1:    cur_byte = HDR_H;
            3'd2:    cur_byte = CH_ASCII_BASE + {6'b0, cur_ch};
            3'd3:    cur_byte = shadow[cur_ch][W-1 -: 8];
            default: cur_byte = shadow[cur_ch][7:0];
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n        = state;
        cur_ch_n       = cur_ch;
        byte_idx_n     = byte_idx;
        tx_start_n     = 1'b0;
        tx_data_n      = tx.tx_data;
        sweep_active_n = sweep_active;
        sweep_done_n   = 1'b0;
        snap_load      = 1'b0;
        case (state)
            IDLE: begin
                if (eligible && !sweep_done && (ch_enable != '0)) begin
                    snap_load      = 1'b1;
                    sweep_active_n = 1'b1;
                    state_n        = SNAP;
                end
            end
            SNAP: begin
                cur_ch_n   = first_ch;
                byte_idx_n = '0;
                state_n    = SEND;
            end
            SEND: begin
                if (!tx.tx_busy) begin
                    tx_start_n = 1'b1;
                    tx_data_n  = cur_byte;
                    state_n    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx.tx_busy) begin
                    state_n = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx.tx_busy) begin
                    if (byte_idx < 3'(FRAME_LEN - 1)) begin
                        byte_idx_n = byte_idx + 3'd1;
                        state_n    = SEND;
                    end else if (next_valid) begin
                        cur_ch_n   = next_ch;
                        byte_idx_n = '0;
                        state_n    = SEND;
                    end else begin
                        sweep_done_n   = 1'b1;
                        sweep_active_n = 1'b0;
                        state_n        = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            cur_ch       <= '0;
            byte_idx     <= '0;
            tx.tx_start  <= 1'b0;
            tx.tx_data   <= '0;
            sweep_active <= 1'b0;
            sweep_done   <= 1'b0;
            drop_count   <= '0;
        end else begin
            cur_ch       <= cur_ch_n;
            byte_idx     <= byte_idx_n;
            tx.tx_start  <= tx_start_n;
            tx.tx_data   <= tx_data_n;
            sweep_active <= sweep_active_n;
            sweep_done   <= sweep_done_n;
            if (drop_hit && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    // NOTE: snapshot storage has no reset; it is only read after a load in IDLE.
    always_ff @(posedge CLK) begin
        if (snap_load) begin
            shadow[0] <= sample_in0;
            shadow[1] <= sample_in1;
            shadow[2] <= sample_in2;
            shadow[3] <= sample_in3;
            mask_q    <= ch_enable;
        end
    end

endmodule

// File: tb/tb_uart_sample_scheduler.sv
// Self-checking bench: transaction-level frame/drop model plus directed scenarios with literal expectations.
module tb_uart_sample_scheduler;

    localparam int W       = 16;
    localparam int DECIM_W = 8;

    logic               CLK = 1'b0;
    logic               rst = 1'b1;
    logic               sample_clk = 1'b0;
    logic [W-1:0]       samp [4];
    logic [3:0]         ch_enable = 4'h0;
    logic [DECIM_W-1:0] decim = '0;
    logic               sweep_active, sweep_done;
    logic [DECIM_W-1:0] drop_count;

    // uart_tx stand-in: busy one cycle after start, held for 10 cycles
    logic uart_busy = 1'b0;
    logic hold_busy = 1'b0;
    logic uart_pend = 1'b0;
    int   uart_cnt  = 0;

    uart_sample_scheduler_if tx_if();
    assign tx_if.tx_busy = uart_busy | hold_busy;

    uart_sample_scheduler #(.W(W), .DECIM_W(DECIM_W)) dut (
        .CLK          (CLK),
        .rst          (rst),
        .sample_clk   (sample_clk),
        .sample_in0   (samp[0]),
        .sample_in1   (samp[1]),
        .sample_in2   (samp[2]),
        .sample_in3   (samp[3]),
        .ch_enable    (ch_enable),
        .decim        (decim),
        .tx           (tx_if.master),
        .sweep_active (sweep_active),
        .sweep_done   (sweep_done),
        .drop_count   (drop_count)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) uart_busy = 1'b0;
        end
        if (uart_pend) begin
            uart_busy = 1'b1;
            uart_cnt  = 10;
            uart_pend = 1'b0;
        end
        if (tx_if.tx_start) uart_pend = 1'b1;
    end

    // Behavioural model: expected byte queue, sweep window and drop count
    logic [7:0] exp_q [$];
    logic [7:0] got [$];
    logic       m_last = 1'b0;
    logic       m_prev_ub = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_rst = 1'b1;
    bit         m_active = 0, m_tail = 0;
    int         m_since = 0, m_drops = 0, m_left = 0, m_sweeps = 0;

    always @(posedge CLK) begin
        bit edg, elig;
        m_busy = tx_if.tx_busy;
        m_rst  = rst;
        if (rst) begin
            m_last   = 1'b0;
            m_since  = 0;
            m_drops  = 0;
            m_active = 0;
            m_tail   = 0;
            m_left   = 0;
            m_sweeps = 0;
            exp_q.delete();
        end else begin
            edg    = sample_clk && !m_last;
            m_last = sample_clk;
            elig   = 0;
            if (edg) begin
                if (m_since >= int'(decim)) begin
                    elig    = 1;
                    m_since = 0;
                end else begin
                    m_since++;
                end
            end
            if (m_tail) begin
                if (elig && m_drops < 255) m_drops++;
                m_tail   = 0;
                m_active = 0;
                m_sweeps++;
            end else if (elig && m_active) begin
                if (m_drops < 255) m_drops++;
            end else if (elig && ch_enable != 4'h0) begin
                m_active = 1;
                m_left   = 0;
                for (int c = 0; c < 4; c++) begin
                    if (ch_enable[c]) begin
                        exp_q.push_back(8'h43);
                        exp_q.push_back(8'h48);
                        exp_q.push_back(8'h30 + 8'(c));
                        exp_q.push_back(samp[c][15:8]);
                        exp_q.push_back(samp[c][7:0]);
                        m_left += 5;
                    end
                end
            end
            if (m_active && !m_tail && m_prev_ub && !uart_busy) begin
                m_left--;
                if (m_left == 0) m_tail = 1;
            end
        end
        m_prev_ub = uart_busy;
    end

    bit         chk_en = 0;
    bit         stab = 0;
    logic [7:0] hold_d = 8'h00;

    always @(negedge CLK) begin
        if (chk_en) begin
            check("drop_count", 32'(drop_count), 32'(m_drops));
            check("sweep_done", 32'(sweep_done), 32'(m_tail));
            check("sweep_active", 32'(sweep_active), 32'(m_active && !m_tail));
            if (m_rst) begin
                stab = 0;
            end else if (stab) begin
                check("tx_data_hold", 32'(tx_if.tx_data), 32'(hold_d));
                if (m_busy) stab = 0;
            end
            if (tx_if.tx_start) begin
                got.push_back(tx_if.tx_data);
                check("start_while_busy", 32'(m_busy), 32'(0));
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_start: got byte 0x%0h expected no start", tx_if.tx_data);
                end else begin
                    check("tx_byte", 32'(tx_if.tx_data), 32'(exp_q.pop_front()));
                end
                stab   = 1;
                hold_d = tx_if.tx_data;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        got.delete();
    endtask

    task automatic pulse_edge();
        @(negedge CLK);
        sample_clk = 1'b1;
        @(negedge CLK);
        sample_clk = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge CLK);
            if (sweep_done) seen = 1;
        end
        check({name, "_sweep_done_seen"}, 32'(seen), 32'(1));
    endtask

    task automatic wait_bytes(input string name, input int n, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge CLK);
            if (got.size() >= n) seen = 1;
        end
        check({name, "_bytes_seen"}, 32'(seen), 32'(1));
    endtask

    logic [7:0] exp_all [20] = '{8'h43, 8'h48, 8'h30, 8'h12, 8'h34,
                                 8'h43, 8'h48, 8'h31, 8'hAB, 8'hCD,
                                 8'h43, 8'h48, 8'h32, 8'h00, 8'h01,
                                 8'h43, 8'h48, 8'h33, 8'h80, 8'h00};
    logic [7:0] exp_sparse [10] = '{8'h43, 8'h48, 8'h31, 8'hAB, 8'hCD,
                                    8'h43, 8'h48, 8'h33, 8'h80, 8'h00};

    initial begin
        samp[0] = 16'h1234;
        samp[1] = 16'hABCD;
        samp[2] = 16'h0001;
        samp[3] = 16'h8000;

        // Reset state
        do_reset();
        chk_en = 1;
        check("rst_tx_start", 32'(tx_if.tx_start), 32'(0));
        check("rst_tx_data", 32'(tx_if.tx_data), 32'(0));
        check("rst_sweep_active", 32'(sweep_active), 32'(0));
        check("rst_sweep_done", 32'(sweep_done), 32'(0));
        check("rst_drop_count", 32'(drop_count), 32'(0));

        // All channels, decim=0
        ch_enable = 4'hF;
        decim     = '0;
        pulse_edge();
        wait_done("all", 400);
        tick(5);
        check("all_byte_count", 32'(got.size()), 32'(20));
        for (int i = 0; i < 20 && i < got.size(); i++) begin
            check($sformatf("all_byte%0d", i), 32'(got[i]), 32'(exp_all[i]));
        end
        check("all_drops", 32'(drop_count), 32'(0));
        check("all_sweeps_model", 32'(m_sweeps), 32'(1));

        // Sparse mask, changed mid-sweep
        do_reset();
        ch_enable = 4'b1010;
        pulse_edge();
        tick(20);
        ch_enable = 4'h1;
        wait_done("sparse", 300);
        tick(5);
        check("sparse_byte_count", 32'(got.size()), 32'(10));
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            check($sformatf("sparse_byte%0d", i), 32'(got[i]), 32'(exp_sparse[i]));
        end

        // Decimation: sweeps only on edges 3, 6, 9
        do_reset();
        ch_enable = 4'h1;
        decim     = 8'd2;
        for (int k = 1; k <= 9; k++) begin
            pulse_edge();
            tick(2);
            check($sformatf("decim_edge%0d", k), 32'(sweep_active), 32'((k % 3) == 0));
            tick(100);
        end
        check("decim_sweeps", 32'(m_sweeps), 32'(3));
        check("decim_bytes", 32'(got.size()), 32'(15));

        // Edge coincident with sweep_done is a drop and starts nothing
        do_reset();
        decim     = '0;
        ch_enable = 4'h1;
        pulse_edge();
        wait_done("coinc", 200);
        sample_clk = 1'b1;
        @(negedge CLK);
        sample_clk = 1'b0;
        check("coinc_drop", 32'(drop_count), 32'(1));
        tick(10);
        check("coinc_no_restart", 32'(sweep_active), 32'(0));
        check("coinc_bytes", 32'(got.size()), 32'(5));

        // Overrun: edges every 50 cycles with a full mask, saturating drops
        do_reset();
        ch_enable = 4'hF;
        for (int i = 0; i < 320; i++) begin
            pulse_edge();
            tick(48);
            if (i == 5) check("overrun_first_sweep_drops", 32'(drop_count), 32'(5));
        end
        check("overrun_saturated", 32'(drop_count), 32'(255));
        wait_done("overrun_tail", 400);

        // Handshake: busy held before the first byte
        do_reset();
        ch_enable = 4'h1;
        @(negedge CLK);
        hold_busy = 1'b1;
        pulse_edge();
        tick(100);
        check("stall_no_start", 32'(got.size()), 32'(0));
        check("stall_active", 32'(sweep_active), 32'(1));
        hold_busy = 1'b0;
        wait_done("stall", 200);
        tick(3);
        check("stall_bytes", 32'(got.size()), 32'(5));

        // Reset during byte 3, then a fresh sweep from CH0
        do_reset();
        ch_enable = 4'hF;
        pulse_edge();
        wait_bytes("midrst", 4, 200);
        tick(3);
        rst = 1'b1;
        @(negedge CLK);
        check("midrst_tx_start", 32'(tx_if.tx_start), 32'(0));
        check("midrst_tx_data", 32'(tx_if.tx_data), 32'(0));
        check("midrst_active", 32'(sweep_active), 32'(0));
        check("midrst_done", 32'(sweep_done), 32'(0));
        check("midrst_drops", 32'(drop_count), 32'(0));
        rst = 1'b0;
        got.delete();
        tick(30);
        pulse_edge();
        wait_bytes("midrst_fresh", 3, 100);
        if (got.size() >= 3) begin
            check("midrst_fresh_b0", 32'(got[0]), 32'(8'h43));
            check("midrst_fresh_b2", 32'(got[2]), 32'(8'h30));
        end
        wait_done("midrst_fresh", 400);

        // Zero mask: edges ignored, not dropped
        do_reset();
        ch_enable = 4'h0;
        for (int i = 0; i < 4; i++) begin
            pulse_edge();
            tick(20);
        end
        check("zero_no_bytes", 32'(got.size()), 32'(0));
        check("zero_drops", 32'(drop_count), 32'(0));
        check("zero_active", 32'(sweep_active), 32'(0));

        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_sample_scheduler.md
Name: uart_sample_scheduler

Overview:
- Sequences the four codec sample channels onto the single UART transmitter for telemetry.
- On a sample_clk rising edge it snapshots all four channels in the same cycle, so there is no inter-channel skew.
- It then streams one 5-byte frame per enabled channel: 'C','H','0'+ch, MSB, LSB.
- Sits between the ak4619 sample bus and uart_tx in top; replaces the ad-hoc FSM there.

Parameters:
- W, 16, sample width in bits; frame carries W[15:8] then W[7:0].
- DECIM_W, 8, width of the decimation divider and the drop counter.

Ports:
- CLK  in  1  system clock, 12 MHz.
- rst  in  1  synchronous reset, active-high.
- sample_clk  in  1  codec sample strobe, CLK-synchronous level; rising edge detected internally.
- sample_in0..sample_in3  in  W each  signed channel samples.
- ch_enable  in  4  per-channel enable mask; bit i enables channel i.
- decim  in  DECIM_W  send every (decim+1)th sample edge; 0 means every edge.
- tx_busy  in  1  uart_tx busy flag.
- tx_start  out  1  one-cycle start pulse to uart_tx.
- tx_data  out  8  byte to uart_tx.
- sweep_active  out  1  high from snapshot until the last frame byte completes.
- sweep_done  out  1  one-cycle pulse when a sweep finishes.
- drop_count  out  DECIM_W  saturating count of eligible edges lost while sweep_active.

Behaviour:
- Reset: tx_start=0, tx_data=0, sweep_active=0, sweep_done=0, drop_count=0, decimation counter=0, last_sample_clk=0, state=IDLE.
- Edge detect: edge = sample_clk & ~last_sample_clk, registered every cycle including during a sweep.
- Decimation counter:
  - Advances on every edge.
  - An edge is eligible when the counter equals decim; the counter then returns to 0.
  - If decim changes while the counter is above the new decim, the next edge is eligible and the counter wraps to 0.
- States: IDLE, SNAP, SEND, WAIT_ACK, WAIT_DONE.
- IDLE, on eligible edge with ch_enable != 0:
  - Latch all four samples and ch_enable into shadow registers in the same cycle.
  - Go to SNAP.
- IDLE, on eligible edge with ch_enable == 0: ignored; not counted as a drop.
- SNAP (one cycle):
  - Select the lowest enabled channel; byte_idx=0; sweep_active=1.
  - Go to SEND.
- SEND:
  - Wait until tx_busy==0.
  - Then drive tx_data with byte[byte_idx] and tx_start=1 for exactly one cycle.
  - Go to WAIT_ACK.
- WAIT_ACK:
  - Hold tx_data stable; wait for tx_busy==1, then go to WAIT_DONE.
  - No timeout: uart_tx must raise busy after a start pulse.
- WAIT_DONE:
  - Wait for tx_busy==0.
  - If byte_idx<4: increment byte_idx and go to SEND.
  - Otherwise advance to the next higher enabled channel in the latched mask and return to SEND with byte_idx=0.
  - If no higher enabled channel remains: pulse sweep_done, clear sweep_active, go to IDLE.
- Byte encoding:
  - byte0='C' (0x43), byte1='H' (0x48), byte2=0x30+ch.
  - byte3=sample[W-1:W-8], byte4=sample[7:0], taken from the latched raw sample with no sign manipulation.
- Minimum inter-byte spacing: one cycle of tx_busy low between frames, plus the SEND cycle.
- Drops: an eligible edge while sweep_active=1 increments drop_count, saturating at all-ones. The edge is not queued.
- Simultaneous edge and sweep completion (sweep_done cycle): that edge is counted as a drop. IDLE is entered on the next cycle.
- Mask or decim changes mid-sweep do not affect the current sweep; they take effect at the next snapshot or edge.
- rst mid-byte: outputs go to reset values on the next cycle. uart_tx may still finish its byte; the scheduler restarts at IDLE and waits for a fresh edge.

Decomposition:
- Package telemetry_pkg holds:
  - the state enum;
  - constants FRAME_LEN=5, HDR_C=8'h43, HDR_H=8'h48, CH_ASCII_BASE=8'h30.
- One sub-module, sample_edge_decim: edge detect plus decimation counter, outputting an eligible-edge pulse.
- Channel select (next enabled bit above the current one) is combinational logic inside the top FSM.

Test Plan:
- Setup: uart_tx model asserts busy 1 cycle after start and holds it 10 cycles.
- All channels, decim=0: ch_enable=4'hF, samples 0x1234/0xABCD/0x0001/0x8000, one edge -> 20 bytes "CH0"12 34 "CH1"AB CD "CH2"00 01 "CH3"80 00, then one sweep_done pulse, drop_count=0.
- Sparse mask: ch_enable=4'b1010 -> only "CH1" and "CH3" frames, in that order. Changing the mask to 4'h1 mid-sweep does not alter the output.
- Decimation: decim=2, 9 edges spaced beyond sweep length -> exactly 3 sweeps, on edges 3, 6 and 9.
- Overrun: edges every 50 cycles with a full mask -> drop_count increments per missed edge and saturates at 255. Simultaneous edge plus sweep_done counts as a drop.
- Handshake: hold tx_busy=1 for 100 cycles before the first byte -> no tx_start until busy falls. tx_data is stable from the start pulse through WAIT_ACK.
- Reset mid-frame, and zero mask:
  - rst asserted during byte 3 -> next cycle all outputs zero, state IDLE; the next edge starts a fresh sweep at "CH0".
  - ch_enable=0 with edges -> no tx_start, drop_count stays 0.
